trak_decoder: RTL and testbench

Quadrature-style trackball decoder: the receiving end of the mouse-to-trackball emulation in the top level. It consumes the 4-bit direction/toggle stream (`trakdata`), resynchronises and deglitches it, and maintains per-axis wrapping step counters plus direction flags. The result is presented as the two 8-bit trackball input bytes the game CPU reads. It sits between the top-level trackball emulation and the game's input multiplexer.

---
 rtl/trak_pkg.sv | 15 +
 rtl/trak_axis.sv | 99 +++++++++
 rtl/trak_decoder.sv | 57 +++++
 tb/tb_trak_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trak_pkg.sv
// Shared constants for the trackball decoder: trakdata bit positions,
// axis indices and the default counter width.
package trak_pkg;

    localparam int unsigned CNT_W_DFLT = 4;

    localparam int unsigned TRAK_XDIR = 3;
    localparam int unsigned TRAK_XTGL = 2;
    localparam int unsigned TRAK_YDIR = 1;
    localparam int unsigned TRAK_YTGL = 0;

    localparam int unsigned AX_X = 1;
    localparam int unsigned AX_Y = 0;

endpackage

// File: rtl/trak_axis.sv
// One trackball axis: resynchronise and deglitch the direction/toggle pair,
// detect toggle edges and keep a wrapping step counter plus direction flag.
module trak_axis #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned FILT  = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_dir,
    input  logic             i_tgl,
    input  logic             i_flip,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_dir,
    output logic             o_step
);

    // Bit 1 carries direction, bit 0 carries toggle through sync and filter.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       w_filt;
    logic             r_tgl_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_step;
    logic             w_edge;
    logic             w_step_dir;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_dir, i_tgl};
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (FILT == 0) begin : g_nofilt
            assign w_filt = r_sync2;
        end else begin : g_filt
            localparam int unsigned FC_W = (FILT > 1) ? $clog2(FILT) : 1;
            logic [1:0]      r_filt;
            logic [FC_W-1:0] r_fcnt [2];

            // A bit is accepted only after differing for FILT consecutive cycles.
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    r_filt <= '0;
                    for (int unsigned b = 0; b < 2; b++) begin
                        r_fcnt[b] <= '0;
                    end
                end else begin
                    for (int unsigned b = 0; b < 2; b++) begin
                        if (r_sync2[b] == r_filt[b]) begin
                            r_fcnt[b] <= '0;
                        end else if (r_fcnt[b] == FC_W'(FILT - 1)) begin
                            r_filt[b] <= r_sync2[b];
                            r_fcnt[b] <= '0;
                        end else begin
                            r_fcnt[b] <= r_fcnt[b] + FC_W'(1);
                        end
                    end
                end
            end

            assign w_filt = r_filt;
        end
    endgenerate

    assign w_edge     = w_filt[0] ^ r_tgl_prev;
    assign w_step_dir = w_filt[1] ^ i_flip;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_tgl_prev <= 1'b0;
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_tgl_prev <= w_filt[0];
            r_step     <= w_edge;
            if (w_edge) begin
                r_dir <= w_step_dir;
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (w_edge) begin
                r_cnt <= w_step_dir ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_dir  = r_dir;
    assign o_step = r_step;

endmodule

// File: rtl/trak_decoder.sv
// Trackball decoder top: two independent axis decoders, shared clear,
// and the combinational byte read mux seen by the game CPU.
module trak_decoder
    import trak_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DFLT,
    parameter int unsigned FILT  = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [3:0]       trak_i,
    input  logic             flip_i,
    input  logic             clr_i,
    input  logic             sel_i,
    output logic [7:0]       rd_o,
    output logic [CNT_W-1:0] cnt_x_o,
    output logic [CNT_W-1:0] cnt_y_o,
    output logic             dir_x_o,
    output logic             dir_y_o,
    output logic [1:0]       step_o
);

    logic w_step_x;
    logic w_step_y;

    trak_axis #(.CNT_W(CNT_W), .FILT(FILT)) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_dir   (trak_i[TRAK_XDIR]),
        .i_tgl   (trak_i[TRAK_XTGL]),
        .i_flip  (flip_i),
        .i_clr   (clr_i),
        .o_cnt   (cnt_x_o),
        .o_dir   (dir_x_o),
        .o_step  (w_step_x)
    );

    trak_axis #(.CNT_W(CNT_W), .FILT(FILT)) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_dir   (trak_i[TRAK_YDIR]),
        .i_tgl   (trak_i[TRAK_YTGL]),
        .i_flip  (flip_i),
        .i_clr   (clr_i),
        .o_cnt   (cnt_y_o),
        .o_dir   (dir_y_o),
        .o_step  (w_step_y)
    );

    assign step_o[AX_X] = w_step_x;
    assign step_o[AX_Y] = w_step_y;

    always_comb begin
        rd_o = sel_i ? {dir_y_o, 7'(cnt_y_o)} : {dir_x_o, 7'(cnt_x_o)};
    end

endmodule

// File: tb/tb_trak_decoder.sv
// Scoreboarded bench for trak_decoder: stimulus pushes expected step events,
// a monitor pops them whenever the DUT pulses step_o.
module tb_trak_decoder;
    import trak_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned FILT  = 2;
    localparam int          LAT   = FILT + 3;
    localparam int          MODV  = 1 << CNT_W;

    typedef struct {
        int cnt;
        bit dir;
        int due;
    } ev_t;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic [3:0]       trak_i;
    logic             flip_i;
    logic             clr_i;
    logic             sel_i;
    logic [7:0]       rd_o;
    logic [CNT_W-1:0] cnt_x_o;
    logic [CNT_W-1:0] cnt_y_o;
    logic             dir_x_o;
    logic             dir_y_o;
    logic [1:0]       step_o;

    trak_decoder #(.CNT_W(CNT_W), .FILT(FILT)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .trak_i  (trak_i),
        .flip_i  (flip_i),
        .clr_i   (clr_i),
        .sel_i   (sel_i),
        .rd_o    (rd_o),
        .cnt_x_o (cnt_x_o),
        .cnt_y_o (cnt_y_o),
        .dir_x_o (dir_x_o),
        .dir_y_o (dir_y_o),
        .step_o  (step_o)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    ev_t qx[$];
    ev_t qy[$];
    int  m_cnt [2];
    bit  m_dir [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Move one axis one step: set its direction, flip its toggle, and predict the result.
    task automatic step_axis(input int ax, input bit d);
        int  dpos;
        int  tpos;
        bit  eff;
        ev_t ev;
        dpos = (ax == AX_X) ? TRAK_XDIR : TRAK_YDIR;
        tpos = (ax == AX_X) ? TRAK_XTGL : TRAK_YTGL;
        trak_i[dpos] = d;
        trak_i[tpos] = ~trak_i[tpos];
        eff = d ^ flip_i;
        m_cnt[ax] = eff ? (m_cnt[ax] + MODV - 1) % MODV : (m_cnt[ax] + 1) % MODV;
        m_dir[ax] = eff;
        ev.cnt = m_cnt[ax];
        ev.dir = eff;
        ev.due = cyc + LAT;
        if (ax == AX_X) qx.push_back(ev);
        else qy.push_back(ev);
    endtask

    task automatic model_reset();
        qx.delete();
        qy.delete();
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_dir[0] = 0; m_dir[1] = 0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        trak_i = '0;
        model_reset();
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((qx.size() + qy.size()) != 0 && n < 40) begin
            tick(1);
            n++;
        end
        if ((qx.size() + qy.size()) != 0) begin
            chk("drain_timeout", qx.size() + qy.size(), 0);
            qx.delete();
            qy.delete();
        end
        tick(2);
    endtask

    always @(negedge clk_sys) begin
        if (reset !== 1'b1) begin
            bit  exp_x;
            bit  exp_y;
            ev_t ev;
            exp_x = (qx.size() > 0) && (qx[0].due == cyc);
            exp_y = (qy.size() > 0) && (qy[0].due == cyc);
            if (step_o[AX_X] || exp_x) chk("x_step_pulse", step_o[AX_X], exp_x);
            if (exp_x) begin
                ev = qx.pop_front();
                chk("x_cnt", cnt_x_o, ev.cnt);
                chk("x_dir", dir_x_o, ev.dir);
            end
            if (step_o[AX_Y] || exp_y) chk("y_step_pulse", step_o[AX_Y], exp_y);
            if (exp_y) begin
                ev = qy.pop_front();
                chk("y_cnt", cnt_y_o, ev.cnt);
                chk("y_dir", dir_y_o, ev.dir);
            end
            if (qx.size() > 0 && qx[0].due < cyc) begin
                chk("x_step_late", cyc, qx[0].due);
                void'(qx.pop_front());
            end
            if (qy.size() > 0 && qy[0].due < cyc) begin
                chk("y_step_late", cyc, qy[0].due);
                void'(qy.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t ev;
        reset  = 1'b1;
        trak_i = '0;
        flip_i = 1'b0;
        clr_i  = 1'b0;
        sel_i  = 1'b0;
        model_reset();
        tick(3);

        // Reset state
        chk("rst_cnt_x", cnt_x_o, 0);
        chk("rst_step", step_o, 0);
        reset = 1'b0;
        tick(3);
        chk("idle_rd_x", rd_o, 8'h00);
        sel_i = 1'b1; #1;
        chk("idle_rd_y", rd_o, 8'h00);
        chk("idle_cnt_y", cnt_y_o, 0);
        chk("idle_dirs", {dir_x_o, dir_y_o}, 2'b00);
        sel_i = 1'b0;

        // 20 forward X steps wrap the counter to 4
        for (int i = 0; i < 20; i++) begin
            step_axis(AX_X, 1'b0);
            tick(4);
        end
        wait_drain();
        chk("x20_cnt", cnt_x_o, 4);
        chk("x20_dir", dir_x_o, 0);
        chk("x20_cnt_y", cnt_y_o, 0);
        chk("x20_rd", rd_o, 8'h04);

        // Y direction and toggle together from reset state
        do_reset();
        step_axis(AX_Y, 1'b1);
        wait_drain();
        chk("y_back_cnt", cnt_y_o, 15);
        chk("y_back_dir", dir_y_o, 1);
        sel_i = 1'b1; #1;
        chk("y_back_rd", rd_o, 8'h8F);
        sel_i = 1'b0; #1;
        chk("y_back_rd_x", rd_o, 8'h00);

        // Flip reverses X
        do_reset();
        flip_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_axis(AX_X, 1'b0);
            tick(4);
        end
        wait_drain();
        chk("flip_cnt", cnt_x_o, 13);
        chk("flip_dir", dir_x_o, 1);
        flip_i = 1'b0;

        // One-cycle glitch is filtered, a held change steps once
        trak_i[TRAK_XTGL] = ~trak_i[TRAK_XTGL];
        tick(1);
        trak_i[TRAK_XTGL] = ~trak_i[TRAK_XTGL];
        tick(12);
        chk("glitch_cnt", cnt_x_o, 13);
        step_axis(AX_X, 1'b0);
        wait_drain();
        chk("held_cnt", cnt_x_o, 14);

        // Clear coinciding with an accepted X step
        step_axis(AX_X, 1'b1);
        ev = qx.pop_back();
        ev.cnt = 0;
        qx.push_back(ev);
        m_cnt[AX_X] = 0;
        m_cnt[AX_Y] = 0;
        tick(LAT - 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        wait_drain();
        chk("clr_cnt_x", cnt_x_o, 0);
        chk("clr_dir_x", dir_x_o, 1);

        // Reset in the middle of filtering a toggle change
        trak_i[TRAK_XTGL] = 1'b0;
        tick(3);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_rd", rd_o, 8'h00);
        chk("midrst_dir_x", dir_x_o, 0);
        chk("midrst_step", step_o, 0);
        tick(2);
        trak_i = '0;
        reset = 1'b0;
        tick(12);
        chk("midrst_after_cnt", {cnt_x_o, cnt_y_o}, 0);

        // Randomized traffic on both axes
        for (int i = 0; i < 96; i++) begin
            int r;
            if (i % 16 == 15) begin
                wait_drain();
                sel_i = 1'($urandom_range(0, 1)); #1;
                if (sel_i) chk("rand_rd_y", rd_o, {m_dir[AX_Y], 3'b000, 4'(m_cnt[AX_Y])});
                else chk("rand_rd_x", rd_o, {m_dir[AX_X], 3'b000, 4'(m_cnt[AX_X])});
                if ($urandom_range(0, 2) == 0) begin
                    clr_i = 1'b1;
                    m_cnt[0] = 0; m_cnt[1] = 0;
                    tick(1);
                    clr_i = 1'b0;
                    tick(1);
                    chk("rand_clr", {cnt_x_o, cnt_y_o}, 0);
                end
                flip_i = 1'($urandom_range(0, 1));
                tick(1);
            end
            r = $urandom_range(1, 3);
            if (r[0]) step_axis(AX_X, 1'($urandom_range(0, 1)));
            if (r[1]) step_axis(AX_Y, 1'($urandom_range(0, 1)));
            tick($urandom_range(4, 7));
        end
        wait_drain();
        chk("final_cnt_x", cnt_x_o, m_cnt[AX_X]);
        chk("final_cnt_y", cnt_y_o, m_cnt[AX_Y]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
